// File: rtl/audio_sequencer_if.sv
// Control/output bundle between game logic (master) and audio_sequencer (slave).
// The i_loop signal exists only when AUDIO_SEQ_LOOP_EN is defined.
interface audio_sequencer_if;
    logic        i_play;
    logic [1:0]  i_effect;
    logic        i_stop;
`ifdef AUDIO_SEQ_LOOP_EN
    logic        i_loop;
`endif
    logic [23:0] o_freq;
    logic        o_busy;
    logic        o_done;

`ifdef AUDIO_SEQ_LOOP_EN
    modport master (output i_play, i_effect, i_stop, i_loop,
                    input  o_freq, o_busy, o_done);
    modport slave  (input  i_play, i_effect, i_stop, i_loop,
                    output o_freq, o_busy, o_done);
`else
    modport master (output i_play, i_effect, i_stop,
                    input  o_freq, o_busy, o_done);
    modport slave  (input  i_play, i_effect, i_stop,
                    output o_freq, o_busy, o_done);
`endif
endinterface

// File: rtl/audio_sequencer.sv
// Sound-effect sequencer: walks a (freq, dur) tune table and drives a note generator.
// Optional feature macro: AUDIO_SEQ_LOOP_EN (adds i_loop, repeating tunes).
module audio_sequencer #(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned TICK_MS  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    audio_sequencer_if.slave  bus
);

    localparam int unsigned TICK_DIV  = CLK_FREQ / 1000 * TICK_MS;
    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t      state, state_n;
    logic [1:0]  eff, eff_n;
    logic [3:0]  idx, idx_n;
    logic [23:0] tick_cnt, tick_n;
    logic [7:0]  dur_cnt, dur_n;
    logic [23:0] freq_q, freq_n;
    logic        done_q, done_n;

    logic [23:0] tbl_freq;
    logic [7:0]  tbl_dur;
    logic        loop_req;
    logic [7:0]  dur_inc;

    // Entry 15 is never listed, so it always reads as an end marker.
    always_comb begin
        tbl_freq = '0;
        tbl_dur  = '0;
        case ({eff, idx})
            6'h00: begin tbl_freq = 24'd880;  tbl_dur = 8'd2; end
            6'h01: begin tbl_freq = 24'd440;  tbl_dur = 8'd2; end
            6'h10: begin tbl_freq = 24'd110;  tbl_dur = 8'd8; end
            6'h11: begin tbl_freq = 24'd0;    tbl_dur = 8'd2; end
            6'h12: begin tbl_freq = 24'd82;   tbl_dur = 8'd8; end
            6'h20: begin tbl_freq = 24'd1000; tbl_dur = 8'd3; end
            6'h21: begin tbl_freq = 24'd500;  tbl_dur = 8'd1; end
            6'h22: begin tbl_freq = 24'd0;    tbl_dur = 8'd1; end
            6'h23: begin tbl_freq = 24'd2000; tbl_dur = 8'd2; end
            6'h30: begin tbl_freq = 24'd1500; tbl_dur = 8'd1; end
            6'h31: begin tbl_freq = 24'd1200; tbl_dur = 8'd1; end
            6'h32: begin tbl_freq = 24'd900;  tbl_dur = 8'd1; end
            6'h33: begin tbl_freq = 24'd600;  tbl_dur = 8'd1; end
            default: begin tbl_freq = '0; tbl_dur = '0; end
        endcase
    end

`ifdef AUDIO_SEQ_LOOP_EN
    assign loop_req = bus.i_loop;
`else
    assign loop_req = 1'b0;
`endif

    assign dur_inc = dur_cnt + 8'd1;

    always_comb begin
        state_n = state;
        eff_n   = eff;
        idx_n   = idx;
        tick_n  = tick_cnt;
        dur_n   = dur_cnt;
        freq_n  = freq_q;
        done_n  = 1'b0;
        if (bus.i_stop) begin
            state_n = IDLE;
            idx_n   = '0;
            tick_n  = '0;
            dur_n   = '0;
            freq_n  = '0;
        end else if (state != IDLE && bus.i_play && bus.i_effect > eff) begin
            // Pre-emption restarts the new tune; the old note holds through its LOAD.
            eff_n   = bus.i_effect;
            idx_n   = '0;
            state_n = LOAD;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_play) begin
                        eff_n   = bus.i_effect;
                        idx_n   = '0;
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    if (tbl_dur == 8'd0) begin
                        idx_n = '0;
                        if (loop_req) begin
                            state_n = LOAD;
                        end else begin
                            freq_n  = '0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        freq_n  = tbl_freq;
                        tick_n  = '0;
                        dur_n   = '0;
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        dur_n  = dur_inc;
                        if (dur_inc == tbl_dur) begin
                            idx_n   = idx + 4'd1;
                            state_n = LOAD;
                        end
                    end else begin
                        tick_n = tick_cnt + 24'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            eff      <= '0;
            idx      <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            freq_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            eff      <= eff_n;
            idx      <= idx_n;
            tick_cnt <= tick_n;
            dur_cnt  <= dur_n;
            freq_q   <= freq_n;
            done_q   <= done_n;
        end
    end

    assign bus.o_freq = freq_q;
    assign bus.o_done = done_q;
    assign bus.o_busy = (state != IDLE);

endmodule

// File: tb/tb_audio_sequencer.sv
// Scoreboard bench for audio_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_audio_sequencer;

    typedef struct packed {
        logic [23:0] f;
        logic        b;
        logic        d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    audio_sequencer_if bus ();

    audio_sequencer #(.CLK_FREQ(1000), .TICK_MS(1)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (bus.o_freq !== e.f || bus.o_busy !== e.b || bus.o_done !== e.d) begin
                    bad++;
                    $display("FAIL cycle t=%0t: got freq=%0d busy=%0b done=%0b, want freq=%0d busy=%0b done=%0b",
                             $time, bus.o_freq, bus.o_busy, bus.o_done, e.f, e.b, e.d);
                end
            end
        end
    end

    task automatic run(input logic [23:0] f, input logic b, input logic d, input int n);
        exp_t e;
        e.f = f;
        e.b = b;
        e.d = d;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic pulse(input logic p, input logic [1:0] eff, input logic s);
        bus.i_play   = p;
        bus.i_effect = eff;
        bus.i_stop   = s;
        @(posedge clk);
        #1;
        bus.i_play = 1'b0;
        bus.i_stop = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain timeout: got %0d entries left, want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_play   = 1'b0;
        bus.i_effect = 2'd0;
        bus.i_stop   = 1'b0;
`ifdef AUDIO_SEQ_LOOP_EN
        bus.i_loop   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(0, 0, 0, 3);
        drain();

        // effect 0 one-shot
        run(0, 1, 0, 1); run(880, 1, 0, 3); run(440, 1, 0, 3);
        run(0, 0, 1, 1); run(0, 0, 0, 2);
        pulse(1, 2'd0, 0); drain();

        // effect 1 with a rest
        run(0, 1, 0, 1); run(110, 1, 0, 9); run(0, 1, 0, 3); run(82, 1, 0, 9);
        run(0, 0, 1, 1); run(0, 0, 0, 2);
        pulse(1, 2'd1, 0); drain();

        // lower-priority request ignored
        run(0, 1, 0, 1); run(110, 1, 0, 4);
        pulse(1, 2'd1, 0); drain();
        run(110, 1, 0, 5); run(0, 1, 0, 3); run(82, 1, 0, 9);
        run(0, 0, 1, 1); run(0, 0, 0, 2);
        pulse(1, 2'd0, 0); drain();

        // higher-priority pre-emption
        run(0, 1, 0, 1); run(110, 1, 0, 3);
        pulse(1, 2'd1, 0); drain();
        run(110, 1, 0, 1); run(1000, 1, 0, 4); run(500, 1, 0, 2); run(0, 1, 0, 2);
        run(2000, 1, 0, 3); run(0, 0, 1, 1); run(0, 0, 0, 2);
        pulse(1, 2'd2, 0); drain();

        // effect 3, single-tick notes
        run(0, 1, 0, 1); run(1500, 1, 0, 2); run(1200, 1, 0, 2); run(900, 1, 0, 2);
        run(600, 1, 0, 2); run(0, 0, 1, 1); run(0, 0, 0, 2);
        pulse(1, 2'd3, 0); drain();

        // stop mid-note, no done
        run(0, 1, 0, 1); run(110, 1, 0, 4);
        pulse(1, 2'd1, 0); drain();
        run(0, 0, 0, 4);
        pulse(0, 2'd0, 1); drain();

        // stop together with play while idle
        run(0, 0, 0, 4);
        pulse(1, 2'd2, 1); drain();

        // stop beats a higher-priority play while busy
        run(0, 1, 0, 1); run(880, 1, 0, 2);
        pulse(1, 2'd0, 0); drain();
        run(0, 0, 0, 3);
        pulse(1, 2'd3, 1); drain();

        // reset mid-tune silences output
        run(0, 1, 0, 1); run(110, 1, 0, 3);
        pulse(1, 2'd1, 0); drain();
        rst = 1'b1;
        run(0, 0, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(0, 0, 0, 2);
        drain();

`ifdef AUDIO_SEQ_LOOP_EN
        // looping effect 0, then release the loop
        bus.i_loop = 1'b1;
        run(0, 1, 0, 1); run(880, 1, 0, 3); run(440, 1, 0, 4); run(880, 1, 0, 3);
        run(440, 1, 0, 4); run(880, 1, 0, 2);
        pulse(1, 2'd0, 0); drain();
        bus.i_loop = 1'b0;
        run(880, 1, 0, 1); run(440, 1, 0, 3); run(0, 0, 1, 1); run(0, 0, 0, 2);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
